// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter: FSM state encoding and port ids.
package sram_arb_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = IDLE,
    StAccess  = ACCESS,
    StCapture = CAPTURE,
    StDone    = DONE
  } arb_state_e;

  localparam logic PORT_HOST = 1'b0;
  localparam logic PORT_CORE = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side SRAM port: latched request fields, one-cycle ack and held read data.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/sram_arb_picker.sv
// Combinational winner select for the SRAM arbiter.
// ARB_ROUND_ROBIN_EN selects alternating priority on contention; default is fixed host priority.
module sram_arb_picker
  import sram_arb_pkg::*;
(
  input  logic host_req,
  input  logic core_req_eff,
  input  logic last_winner,
  output logic winner,
  output logic any_req
);

  assign any_req = host_req | core_req_eff;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = PORT_HOST;
    if (host_req && core_req_eff) begin
      winner = (last_winner == PORT_HOST) ? PORT_CORE : PORT_HOST;
    end else if (core_req_eff) begin
      winner = PORT_CORE;
    end
  end
`else
  logic unused_last_winner;
  assign unused_last_winner = last_winner;

  always_comb begin
    winner = PORT_HOST;
    if (!host_req && core_req_eff) begin
      winner = PORT_CORE;
    end
  end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the host command path and the core bus.
// Optional ARB_ROUND_ROBIN_EN (in sram_arb_picker) enables round-robin arbitration.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram_port_arbiter_if.slave     host,
  input  logic                   core_en,
  sram_port_arbiter_if.slave     core,
  output logic                   csb_n,
  output logic                   we_n,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_W-1:0]      din,
  input  logic [DATA_W-1:0]      dout
);

  arb_state_e        state_q, state_d;
  logic              winner_q, we_q, last_winner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] host_rdata_q, core_rdata_q;

  logic core_req_eff;
  logic winner, any_req;

  assign core_req_eff = core.req & core_en;

  sram_arb_picker u_picker (
    .host_req     (host.req),
    .core_req_eff (core_req_eff),
    .last_winner  (last_winner_q),
    .winner       (winner),
    .any_req      (any_req)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (any_req) state_d = StAccess;
      StAccess:  state_d = we_q ? StDone : StCapture;
      StCapture: state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // SRAM pins depend only on state and latched fields, so they fall back to idle values on reset.
  always_comb begin
    csb_n = 1'b1;
    we_n  = 1'b1;
    addr  = '0;
    din   = '0;
    if (state_q == StAccess) begin
      csb_n = 1'b0;
      we_n  = ~we_q;
      addr  = addr_q;
      din   = we_q ? wdata_q : '0;
    end
  end

  assign host.ack   = (state_q == StDone) && (winner_q == PORT_HOST);
  assign core.ack   = (state_q == StDone) && (winner_q == PORT_CORE);
  assign host.rdata = host_rdata_q;
  assign core.rdata = core_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      winner_q      <= PORT_HOST;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      last_winner_q <= PORT_CORE;
      host_rdata_q  <= '0;
      core_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && any_req) begin
        winner_q <= winner;
        we_q     <= (winner == PORT_HOST) ? host.we    : core.we;
        addr_q   <= (winner == PORT_HOST) ? host.addr  : core.addr;
        wdata_q  <= (winner == PORT_HOST) ? host.wdata : core.wdata;
      end
      // dout is valid in the cycle after the read select.
      if (state_q == StCapture) begin
        if (winner_q == PORT_HOST) host_rdata_q <= dout;
        else                       core_rdata_q <= dout;
      end
      if (state_q == StDone) begin
        last_winner_q <= winner_q;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed plan steps plus random traffic
// against a transaction-level memory/arbitration model.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          core_en = 1'b0;
  logic          csb_n, we_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout = '0;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) host_if ();
  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) core_if ();

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (host_if.slave),
    .core_en (core_en),
    .core    (core_if.slave),
    .csb_n   (csb_n),
    .we_n    (we_n),
    .addr    (addr),
    .din     (din),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  // SRAM macro behaviour: synchronous write, read data one cycle after select.
  logic [DW-1:0] sram [32] = '{default: '0};
  always @(posedge clk) begin
    if (!csb_n) begin
      if (!we_n) sram[addr] <= din;
      else       dout <= sram[addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [DW-1:0] exp_mem [32];
  logic [DW-1:0] exp_rd [2];
  logic          model_last;
  int            n_assert = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic contention_winner();
`ifdef ARB_ROUND_ROBIN_EN
    return (model_last == PORT_HOST) ? PORT_CORE : PORT_HOST;
`else
    return PORT_HOST;
`endif
  endfunction

  function automatic int lat_of(input logic we);
    return we ? 2 : 3;
  endfunction

  task automatic drive(input logic p, input logic r, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (p == PORT_HOST) begin
      host_if.req = r; host_if.we = we; host_if.addr = a; host_if.wdata = d;
    end else begin
      core_if.req = r; core_if.we = we; core_if.addr = a; core_if.wdata = d;
    end
  endtask

  function automatic logic ack_of(input logic p);
    return (p == PORT_HOST) ? host_if.ack : core_if.ack;
  endfunction

  function automatic logic [DW-1:0] rdata_of(input logic p);
    return (p == PORT_HOST) ? host_if.rdata : core_if.rdata;
  endfunction

  // Single transaction on one port; starts just after a rising edge with the DUT idle.
  task automatic run_txn(input string tag, input logic p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int ack_at);
    int lat = -1;
    int sel = 0;
    logic other = 1'b0;
    logic [DW-1:0] rd = '0;
    drive(p, 1'b1, we, a, d);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!csb_n) sel++;
      if (ack_of(!p)) other = 1'b1;
      if (c == 0) check({tag, "_idle_ack"}, 32'(ack_of(p)), 32'd0);
      if (c == 1) begin
        check({tag, "_csb"}, 32'(csb_n), 32'd0);
        check({tag, "_we_n"}, 32'(we_n), 32'(!we));
        check({tag, "_addr"}, 32'(addr), 32'(a));
        check({tag, "_din"}, din, we ? d : 32'd0);
      end
      if (ack_of(p)) begin
        lat = c;
        rd = rdata_of(p);
        break;
      end
    end
    ack_at = cyc;
    check({tag, "_latency"}, 32'(lat), 32'(lat_of(we)));
    check({tag, "_selects"}, 32'(sel), 32'd1);
    check({tag, "_other_ack"}, 32'(other), 32'd0);
    if (we) begin
      exp_mem[a] = d;
    end else begin
      exp_rd[p] = exp_mem[a];
      check({tag, "_rdata"}, rd, exp_rd[p]);
    end
    check({tag, "_other_rdata"}, rdata_of(!p), exp_rd[!p]);
    model_last = p;
    @(posedge clk);
    #1;
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  // Both ports request in the same idle cycle.
  task automatic contend(input string tag, input logic hwe, input logic [AW-1:0] ha,
                         input logic [DW-1:0] hd, input logic cwe, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd);
    logic          we_p [2];
    logic [AW-1:0] a_p [2];
    logic [DW-1:0] d_p [2];
    int            lat_p [2];
    logic [DW-1:0] rd_p [2];
    int            exp_lat [2];
    logic          w, l, both;
    int            sel;
    we_p[PORT_HOST] = hwe; a_p[PORT_HOST] = ha; d_p[PORT_HOST] = hd;
    we_p[PORT_CORE] = cwe; a_p[PORT_CORE] = ca; d_p[PORT_CORE] = cd;
    lat_p[0] = -1; lat_p[1] = -1;
    rd_p[0] = '0; rd_p[1] = '0;
    both = 1'b0;
    sel = 0;
    w = contention_winner();
    l = !w;
    drive(PORT_HOST, 1'b1, hwe, ha, hd);
    drive(PORT_CORE, 1'b1, cwe, ca, cd);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!csb_n) sel++;
      if (host_if.ack && core_if.ack) both = 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (ack_of(1'(p)) && lat_p[p] < 0) begin
          lat_p[p] = c;
          rd_p[p] = rdata_of(1'(p));
        end
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (lat_p[p] == c) drive(1'(p), 1'b0, 1'b0, '0, '0);
      end
      if (lat_p[0] >= 0 && lat_p[1] >= 0) break;
    end
    drive(PORT_HOST, 1'b0, 1'b0, '0, '0);
    drive(PORT_CORE, 1'b0, 1'b0, '0, '0);
    exp_lat[w] = lat_of(we_p[w]);
    exp_lat[l] = exp_lat[w] + 1 + lat_of(we_p[l]);
    // Winner's access happens first, so a read by the loser sees the winner's write.
    for (int k = 0; k < 2; k++) begin
      logic q;
      q = (k == 0) ? w : l;
      if (we_p[q]) exp_mem[a_p[q]] = d_p[q];
      else         exp_rd[q] = exp_mem[a_p[q]];
    end
    check({tag, "_host_latency"}, 32'(lat_p[PORT_HOST]), 32'(exp_lat[PORT_HOST]));
    check({tag, "_core_latency"}, 32'(lat_p[PORT_CORE]), 32'(exp_lat[PORT_CORE]));
    check({tag, "_both_acks"}, 32'(both), 32'd0);
    check({tag, "_selects"}, 32'(sel), 32'd2);
    check({tag, "_host_rdata"}, rd_p[PORT_HOST], exp_rd[PORT_HOST]);
    check({tag, "_core_rdata"}, rd_p[PORT_CORE], exp_rd[PORT_CORE]);
    model_last = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int t, prev;
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    model_last = PORT_CORE;
    drive(PORT_HOST, 1'b0, 1'b0, '0, '0);
    drive(PORT_CORE, 1'b0, 1'b0, '0, '0);

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_csb", 32'(csb_n), 32'd1);
    check("rst_we_n", 32'(we_n), 32'd1);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_din", din, 32'd0);
    check("rst_host_ack", 32'(host_if.ack), 32'd0);
    check("rst_core_ack", 32'(core_if.ack), 32'd0);
    check("rst_host_rdata", host_if.rdata, 32'd0);
    check("rst_core_rdata", core_if.rdata, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    core_en = 1'b1;

    // Plan 1 and 2: host write then read back
    run_txn("t1_host_wr", PORT_HOST, 1'b1, 5'd5, 32'hDEADBEEF, t);
    run_txn("t2_host_rd", PORT_HOST, 1'b0, 5'd5, 32'h0, t);

    // Plan 3: same-cycle host read and core write of address 3
    contend("t3", 1'b0, 5'd3, 32'h0, 1'b1, 5'd3, 32'h12345678);

    // Plan 4: disabled core is ignored, then served once enabled
    core_en = 1'b0;
    drive(PORT_CORE, 1'b1, 1'b1, 5'd9, 32'hA5A5_5A5A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("t4_masked_csb_%0d", i), 32'(csb_n), 32'd1);
      check($sformatf("t4_masked_ack_%0d", i), 32'(core_if.ack), 32'd0);
    end
    @(posedge clk);
    #1;
    core_en = 1'b1;
    run_txn("t4_core_wr", PORT_CORE, 1'b1, 5'd9, 32'hA5A5_5A5A, t);

    // Plan 5: reset during the access cycle of a host write
    drive(PORT_HOST, 1'b1, 1'b1, 5'd7, 32'hCAFEF00D);
    @(negedge clk);
    @(negedge clk);
    check("t5_access_csb", 32'(csb_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_csb", 32'(csb_n), 32'd1);
    check("t5_rst_we_n", 32'(we_n), 32'd1);
    check("t5_rst_addr", 32'(addr), 32'd0);
    check("t5_rst_din", din, 32'd0);
    check("t5_rst_host_ack", 32'(host_if.ack), 32'd0);
    check("t5_rst_core_ack", 32'(core_if.ack), 32'd0);
    check("t5_rst_host_rdata", host_if.rdata, 32'd0);
    check("t5_rst_core_rdata", core_if.rdata, 32'd0);
    drive(PORT_HOST, 1'b0, 1'b0, '0, '0);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    model_last = PORT_CORE;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t5_post_ack_%0d", i), 32'(host_if.ack), 32'd0);
      check($sformatf("t5_post_csb_%0d", i), 32'(csb_n), 32'd1);
    end
    @(posedge clk);
    #1;
    run_txn("t5_rd_lost_wr", PORT_HOST, 1'b0, 5'd7, 32'h0, t);

    // Random traffic against the model
    for (int i = 0; i < 24; i++) begin
      int unsigned kind;
      kind = $urandom_range(0, 2);
      if (kind < 2) begin
        run_txn($sformatf("rnd%0d", i), 1'(kind), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 31)), $urandom, t);
      end else begin
        contend($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                $urandom, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
      end
    end

    // Plan 6: back-to-back core reads of every address
    prev = 0;
    for (int i = 0; i < 32; i++) begin
      run_txn($sformatf("t6_rd%0d", i), PORT_CORE, 1'b0, AW'(i), 32'h0, t);
      if (i > 0) check($sformatf("t6_spacing%0d", i), 32'(t - prev), 32'd4);
      prev = t;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
